// File: rtl/qeciphy_pchannel_pkg.sv
// ---------------------------------------------------------------------------
// qeciphy_pchannel_pkg
// Shared types and constants for the QECIPHY P-channel initiator.
//   pchan_state_t : handshake FSM state encoding
//   PSTATE_STOP   : power state 0 (PHY stopped)
//   PSTATE_RUN    : power state 1 (PHY running)
// ---------------------------------------------------------------------------
package qeciphy_pchannel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } pchan_state_t;

  localparam logic PSTATE_STOP = 1'b0;
  localparam logic PSTATE_RUN  = 1'b1;

endpackage

// File: rtl/qeciphy_timeout_cnt.sv
// ---------------------------------------------------------------------------
// qeciphy_timeout_cnt
// Saturating phase timer. Counts cycles while enabled, stops at LIMIT.
//   ACLK     : clock
//   rst_n    : asynchronous active-low reset (count returns to 0)
//   clr      : synchronous clear, wins over en
//   en       : count this cycle
//   terminal : count currently equals LIMIT-1
// ---------------------------------------------------------------------------
module qeciphy_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic ACLK,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] TERM_VAL = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX_VAL  = W'(LIMIT);

  logic [W-1:0] count_d, count_q;

  // Saturating at LIMIT (one past the terminal value) makes terminal a
  // single-cycle event per phase, so a clear of the error afterwards sticks.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == TERM_VAL);

endmodule

// File: rtl/qeciphy_pchannel_ctrl.sv
// ---------------------------------------------------------------------------
// qeciphy_pchannel_ctrl
// P-channel initiator for QECIPHY: runs the PREQ/PACCEPT four-phase
// handshake for commands taken on a valid/ready port, with optional
// PACTIVE-driven wake to RUN, plus sticky timeout and protocol errors.
//   ACLK, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_state    : command in; req_ready accepts it (IDLE only)
//   auto_wake_en           : allow PACTIVE to request RUN while stopped
//   busy, done, cur_state  : status; done is a one-cycle completion pulse
//   err_timeout, err_proto : sticky errors, cleared by err_clr
//   PSTATE, PREQ           : to QECIPHY
//   PACCEPT, PACTIVE       : from QECIPHY
// ---------------------------------------------------------------------------
module qeciphy_pchannel_ctrl
  import qeciphy_pchannel_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic INIT_PSTATE    = 1'b0
) (
  input  logic ACLK,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_state,
  output logic req_ready,
  input  logic auto_wake_en,
  output logic busy,
  output logic done,
  output logic cur_state,
  output logic err_timeout,
  output logic err_proto,
  input  logic err_clr,
  output logic PSTATE,
  output logic PREQ,
  input  logic PACCEPT,
  input  logic PACTIVE
);

  pchan_state_t state_d, state_q;
  logic pstate_d, pstate_q;
  logic preq_d, preq_q;
  logic cur_state_d, cur_state_q;
  logic done_d, done_q;
  logic err_timeout_d, err_timeout_q;
  logic err_proto_d, err_proto_q;

  logic take_req;
  logic target;
  logic timer_clr;
  logic timer_en;
  logic timer_term;

  // Explicit command has priority; auto-wake only when nothing is offered.
  always_comb begin
    take_req = 1'b0;
    target   = PSTATE_STOP;
    if (req_valid) begin
      take_req = 1'b1;
      target   = req_state;
    end else if (auto_wake_en && PACTIVE && (cur_state_q == PSTATE_STOP)) begin
      take_req = 1'b1;
      target   = PSTATE_RUN;
    end
  end

  always_comb begin
    state_d     = state_q;
    pstate_d    = pstate_q;
    preq_d      = preq_q;
    cur_state_d = cur_state_q;
    unique case (state_q)
      IDLE: begin
        if (take_req) begin
          if (target != cur_state_q) begin
            pstate_d = target;
            preq_d   = 1'b1;
            state_d  = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (PACCEPT) begin
          preq_d  = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!PACCEPT) begin
          cur_state_d = pstate_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timer restarts on entry to each waiting phase and runs only while waiting.
  assign timer_clr = ((state_q == IDLE) && (state_d == REQ)) ||
                     ((state_q == REQ) && (state_d == RELEASE));
  assign timer_en  = (state_q == REQ) || (state_q == RELEASE);

  qeciphy_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .ACLK     (ACLK),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .en       (timer_en),
    .terminal (timer_term)
  );

  // Registered done is high exactly while the FSM sits in DONE.
  // For the sticky errors a new set beats a simultaneous clear.
  always_comb begin
    done_d        = (state_d == DONE);
    err_timeout_d = (timer_en && timer_term) || (err_timeout_q && !err_clr);
    err_proto_d   = ((state_q == IDLE) && PACCEPT) || (err_proto_q && !err_clr);
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pstate_q      <= INIT_PSTATE;
      preq_q        <= 1'b0;
      cur_state_q   <= INIT_PSTATE;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pstate_q      <= pstate_d;
      preq_q        <= preq_d;
      cur_state_q   <= cur_state_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cur_state   = cur_state_q;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;
  assign PSTATE      = pstate_q;
  assign PREQ        = preq_q;

endmodule

// File: tb/tb_qeciphy_pchannel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qeciphy_pchannel_ctrl
// Directed bench for the P-channel initiator. Each vector drives inputs for
// one clock edge and lists the outputs expected just after that edge,
// packed as {PREQ, PSTATE, busy, req_ready, done, cur_state, err_timeout,
// err_proto}. Stimulus bits are {req_valid, req_state, auto_wake_en,
// PACCEPT, PACTIVE, err_clr}.
// ---------------------------------------------------------------------------
module tb_qeciphy_pchannel_ctrl;

  typedef struct {
    logic [5:0] stim;
    logic [7:0] exp;
  } vec_t;

  logic ACLK = 1'b0;
  logic rst_n;
  logic req_valid, req_state, req_ready, auto_wake_en;
  logic busy, done, cur_state, err_timeout, err_proto, err_clr;
  logic PSTATE, PREQ, PACCEPT, PACTIVE;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  qeciphy_pchannel_ctrl #(
    .TIMEOUT_CYCLES (16),
    .INIT_PSTATE    (1'b0)
  ) dut (
    .ACLK         (ACLK),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_state    (req_state),
    .req_ready    (req_ready),
    .auto_wake_en (auto_wake_en),
    .busy         (busy),
    .done         (done),
    .cur_state    (cur_state),
    .err_timeout  (err_timeout),
    .err_proto    (err_proto),
    .err_clr      (err_clr),
    .PSTATE       (PSTATE),
    .PREQ         (PREQ),
    .PACCEPT      (PACCEPT),
    .PACTIVE      (PACTIVE)
  );

  always #5 ACLK = ~ACLK;

  function automatic vec_t mk(logic [5:0] s, logic [7:0] e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    return v;
  endfunction

  // Drive one set of inputs, clock once, settle just after the edge.
  task automatic applyStimulus(input logic [5:0] s);
    {req_valid, req_state, auto_wake_en, PACCEPT, PACTIVE, err_clr} = s;
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {PREQ, PSTATE, busy, req_ready, done, cur_state, err_timeout, err_proto};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b (PREQ,PSTATE,busy,ready,done,cur,eto,epr)",
               name, act, exp);
    end
  endtask

  initial begin
    // Full handshake to RUN, PHY accepts 2 cycles after PREQ
    vecs.push_back(mk(6'b110000, 8'b11100000));
    vecs.push_back(mk(6'b000000, 8'b11100000));
    vecs.push_back(mk(6'b000100, 8'b01100000));
    vecs.push_back(mk(6'b000100, 8'b01100000));
    vecs.push_back(mk(6'b000000, 8'b01101100));
    vecs.push_back(mk(6'b000000, 8'b01010100));
    // Request to the state already held: straight to DONE, no PREQ
    vecs.push_back(mk(6'b110000, 8'b01101100));
    vecs.push_back(mk(6'b000000, 8'b01010100));
    // Back to STOP with a zero-latency PHY
    vecs.push_back(mk(6'b100000, 8'b10100100));
    vecs.push_back(mk(6'b000100, 8'b00100100));
    vecs.push_back(mk(6'b000000, 8'b00101000));
    vecs.push_back(mk(6'b000000, 8'b00010000));
    // Auto-wake on PACTIVE
    vecs.push_back(mk(6'b001010, 8'b11100000));
    vecs.push_back(mk(6'b001110, 8'b01100000));
    vecs.push_back(mk(6'b001010, 8'b01101100));
    vecs.push_back(mk(6'b000000, 8'b01010100));
    // Back to STOP, then explicit STOP request beats auto-wake
    vecs.push_back(mk(6'b100000, 8'b10100100));
    vecs.push_back(mk(6'b000100, 8'b00100100));
    vecs.push_back(mk(6'b000000, 8'b00101000));
    vecs.push_back(mk(6'b000000, 8'b00010000));
    vecs.push_back(mk(6'b101010, 8'b00101000));
    vecs.push_back(mk(6'b000000, 8'b00010000));
    // PACCEPT in IDLE: sticky protocol error, set beats clear
    vecs.push_back(mk(6'b000100, 8'b00010001));
    vecs.push_back(mk(6'b000000, 8'b00010001));
    vecs.push_back(mk(6'b000001, 8'b00010000));
    vecs.push_back(mk(6'b000101, 8'b00010001));
    vecs.push_back(mk(6'b000001, 8'b00010000));

    rst_n = 1'b0;
    {req_valid, req_state, auto_wake_en, PACCEPT, PACTIVE, err_clr} = 6'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("reset_state", 8'b00010000);
    @(negedge ACLK);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // PHY never accepts: timeout after 16 REQ cycles, PREQ stays high
    applyStimulus(6'b110000);
    checkOutput("to_accept", 8'b11100000);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(6'b000000);
      checkOutput($sformatf("to_wait%0d", k), 8'b11100000);
    end
    applyStimulus(6'b000000);
    checkOutput("to_set", 8'b11100010);
    applyStimulus(6'b000100);
    checkOutput("to_late_accept", 8'b01100010);
    applyStimulus(6'b000000);
    checkOutput("to_late_done", 8'b01101110);
    applyStimulus(6'b000000);
    checkOutput("to_idle", 8'b01010110);
    applyStimulus(6'b000001);
    checkOutput("to_clear", 8'b01010100);

    // Timeout set coincides with err_clr: set wins, next clear works
    applyStimulus(6'b100000);
    checkOutput("to2_accept", 8'b10100100);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(6'b000000);
      checkOutput($sformatf("to2_wait%0d", k), 8'b10100100);
    end
    applyStimulus(6'b000001);
    checkOutput("to2_set_vs_clr", 8'b10100110);
    applyStimulus(6'b000001);
    checkOutput("to2_clear", 8'b10100100);
    applyStimulus(6'b000100);
    checkOutput("to2_release", 8'b00100100);
    applyStimulus(6'b000000);
    checkOutput("to2_done", 8'b00101000);
    applyStimulus(6'b000000);
    checkOutput("to2_idle", 8'b00010000);

    // Reset asserted mid-handshake drops PREQ without a clock edge
    applyStimulus(6'b110000);
    checkOutput("rst_mid_req", 8'b11100000);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_async", 8'b00010000);
    @(negedge ACLK);
    rst_n = 1'b1;
    applyStimulus(6'b000000);
    checkOutput("rst_mid_after", 8'b00010000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
